// File: rtl/podium_motion_sequencer.sv
// podium_motion_sequencer
// Owns the podium overlay anchor (xpos, ypos) and walks it toward a commanded
// target a fixed number of pixels per frame. Position only changes right after
// the vertical-blanking frame tick, so the renderer never sees a torn podium.
//
// Optional build macro: PODIUM_SEQ_CLAMP_EN
//   defined   -> accepted targets are clamped to [X_MIN,X_MAX] x [Y_MIN,Y_MAX]
//   undefined -> accepted targets are latched raw
module podium_motion_sequencer #(
  parameter int RESET_X         = 250,
  parameter int RESET_Y         = 215,
  parameter int FRAME_TICK_LINE = 516,
  parameter int X_MIN           = 174,
  parameter int X_MAX           = 753,
  parameter int Y_MIN           = 45,
  parameter int Y_MAX           = 474
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [9:0] cmd_x,
  input  logic [9:0] cmd_y,
  input  logic [3:0] cmd_step,
  input  logic       abort,
  output logic [9:0] xpos,
  output logic [9:0] ypos,
  output logic       busy,
  output logic       done,
  output logic       frame_tick
);

  localparam logic [9:0] RST_X     = 10'(RESET_X);
  localparam logic [9:0] RST_Y     = 10'(RESET_Y);
  localparam logic [9:0] TICK_LINE = 10'(FRAME_TICK_LINE);
  localparam logic [9:0] X_LO      = 10'(X_MIN);
  localparam logic [9:0] X_HI      = 10'(X_MAX);
  localparam logic [9:0] Y_LO      = 10'(Y_MIN);
  localparam logic [9:0] Y_HI      = 10'(Y_MAX);

`ifdef PODIUM_SEQ_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_MOVING = 2'd2
  } state_t;

  // Saturate a coordinate into [lo, hi].
  function automatic logic [9:0] clamp10(input logic [9:0] v,
                                         input logic [9:0] lo,
                                         input logic [9:0] hi);
    logic [9:0] r;
    r = v;
    if (v < lo) r = lo;
    else if (v > hi) r = hi;
    return r;
  endfunction

  // One frame's worth of motion on a single axis: move by the step but land
  // exactly on the target when it is within reach. A step of 0 means jump.
  // The 11-bit signed difference keeps the full +/-1023 range, so the result
  // can neither overshoot nor wrap through 0/1023.
  function automatic logic [9:0] approach(input logic [9:0] cur,
                                          input logic [9:0] tgt,
                                          input logic [3:0] step);
    logic signed [10:0] diff;
    logic        [10:0] mag;
    logic        [9:0]  r;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    mag  = diff[10] ? 11'(-diff) : 11'(diff);
    if ((step == 4'd0) || (mag <= {7'd0, step})) r = tgt;
    else if (diff[10]) r = cur - {6'd0, step};
    else r = cur + {6'd0, step};
    return r;
  endfunction

  state_t     state_q;
  logic [9:0] x_q, y_q;
  logic [9:0] tgt_x_q, tgt_y_q;
  logic [3:0] step_q;
  logic       cmd_ready_q, busy_q, done_q;
  logic       tick_cond_q, frame_tick_q;

  logic       tick_cond_d;
  logic [9:0] tgt_x_d, tgt_y_d;
  logic [9:0] next_x_d, next_y_d;
  logic       arrived_d;

  // hCount may sit at 0 for several clocks, so only the first cycle of the
  // blanking-line condition produces a tick.
  assign tick_cond_d = (hCount == 10'd0) && (vCount == TICK_LINE);

  // Target as it will be latched on acceptance (optionally clamped).
  assign tgt_x_d = CLAMP_EN ? clamp10(cmd_x, X_LO, X_HI) : cmd_x;
  assign tgt_y_d = CLAMP_EN ? clamp10(cmd_y, Y_LO, Y_HI) : cmd_y;

  // Candidate position for the next frame update and whether it finishes the move.
  assign next_x_d  = approach(x_q, tgt_x_q, step_q);
  assign next_y_d  = approach(y_q, tgt_y_q, step_q);
  assign arrived_d = (next_x_d == tgt_x_q) && (next_y_d == tgt_y_q);

  // Register the tick condition and emit a single-cycle pulse on its rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cond_q  <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      tick_cond_q  <= tick_cond_d;
      frame_tick_q <= tick_cond_d & ~tick_cond_q;
    end
  end

  // Move sequencer: accept a command, then update position on frame ticks
  // until the target is reached or the move is aborted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      x_q         <= RST_X;
      y_q         <= RST_Y;
      tgt_x_q     <= 10'd0;
      tgt_y_q     <= 10'd0;
      step_q      <= 4'd0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          // abort has no meaning here; a command offered alongside it is taken.
          if (cmd_valid) begin
            tgt_x_q     <= tgt_x_d;
            tgt_y_q     <= tgt_y_d;
            step_q      <= cmd_step;
            state_q     <= S_ARMED;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        S_ARMED, S_MOVING: begin
          if (abort) begin
            // Abort beats a coincident tick: position stays frozen, no done.
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end else if (frame_tick_q) begin
            x_q <= next_x_d;
            y_q <= next_y_d;
            if (arrived_d) begin
              state_q     <= S_IDLE;
              cmd_ready_q <= 1'b1;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              state_q <= S_MOVING;
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign frame_tick = frame_tick_q;
  assign xpos       = x_q;
  assign ypos       = y_q;

endmodule

// File: tb/tb_podium_motion_sequencer.sv
// Testbench for podium_motion_sequencer: compressed raster generator, a
// behavioural reference model checked every cycle, a table of moves with
// expected end points and frame counts, and directed corner-case sequences.
module tb_podium_motion_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] hCount, vCount;
  logic       cmd_valid, cmd_ready, abort;
  logic [9:0] cmd_x, cmd_y;
  logic [3:0] cmd_step;
  logic [9:0] xpos, ypos;
  logic       busy, done, frame_tick;

  int checks = 0;
  int errors = 0;

  podium_motion_sequencer dut (
    .clk(clk), .rst(rst), .hCount(hCount), .vCount(vCount),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_step(cmd_step), .abort(abort),
    .xpos(xpos), .ypos(ypos), .busy(busy), .done(done), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- raster generator (drives 2 time units after posedge) ----
  int frame_cnt = 0;
  bit rand_hold = 0;

  task automatic raster_line(input int vc, input int zeros, input int others);
    for (int i = 0; i < zeros; i++) begin
      @(posedge clk); #2;
      vCount = 10'(vc); hCount = 10'd0;
    end
    for (int i = 0; i < others; i++) begin
      @(posedge clk); #2;
      hCount = 10'(5 + i);
    end
  endtask

  initial begin
    hCount = 10'd3; vCount = 10'd0;
    forever begin
      int hold;
      hold = rand_hold ? int'($urandom_range(1, 6)) : 4;
      frame_cnt++;
      raster_line(100, 3, 3);
      raster_line(300, 1, 2);
      raster_line(515, 1, 1);
      raster_line(516, hold, 2);
      raster_line(517, 1, 1);
    end
  end

  // ---------------- reference model -----------------------------------------
  function automatic int approach(input int cur, input int tgt, input int step);
    int d, m;
    d = tgt - cur;
    m = (d < 0) ? -d : d;
    if (step == 0 || m <= step) return tgt;
    return (d < 0) ? cur - step : cur + step;
  endfunction

  function automatic int clampv(input int v, input int lo, input int hi);
`ifdef PODIUM_SEQ_CLAMP_EN
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
`else
    if (lo > hi) return v;  // bounds only matter in the clamped build
    return v;
`endif
  endfunction

  int m_x, m_y, m_tx, m_ty, m_step;
  bit m_busy, m_done, m_tick, m_cond;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_x <= 250; m_y <= 215; m_tx <= 0; m_ty <= 0; m_step <= 0;
      m_busy <= 0; m_done <= 0; m_tick <= 0; m_cond <= 0;
    end else begin
      bit cnd;
      int nx, ny;
      cnd = (hCount == 10'd0) && (vCount == 10'd516);
      m_tick <= cnd && !m_cond;
      m_cond <= cnd;
      m_done <= 0;
      if (!m_busy) begin
        if (cmd_valid) begin
          m_tx <= clampv(int'(cmd_x), 174, 753);
          m_ty <= clampv(int'(cmd_y), 45, 474);
          m_step <= int'(cmd_step);
          m_busy <= 1;
        end
      end else if (abort) begin
        m_busy <= 0;
      end else if (m_tick) begin
        nx = approach(m_x, m_tx, m_step);
        ny = approach(m_y, m_ty, m_step);
        m_x <= nx;
        m_y <= ny;
        if (nx == m_tx && ny == m_ty) begin
          m_busy <= 0;
          m_done <= 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  bit mon_en = 0;
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      logic [23:0] act, exp;
      act = {xpos, ypos, busy, cmd_ready, done, frame_tick};
      exp = {10'(m_x), 10'(m_y), m_busy, !m_busy, m_done, m_tick};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL model x/y/busy/rdy/done/tick actual=%0d/%0d/%b/%b/%b/%b expected=%0d/%0d/%b/%b/%b/%b t=%0t",
                 xpos, ypos, busy, cmd_ready, done, frame_tick,
                 m_x, m_y, m_busy, !m_busy, m_done, m_tick, $time);
      end
    end
  end

  // Position must never move while the scan is in the visible lines.
  int vis_changes = 0;
  logic [9:0] prev_x, prev_y;
  bit prev_ok = 0;
  always @(negedge clk) begin
    if (!rst && prev_ok && vCount >= 10'd35 && vCount <= 10'd514 &&
        (xpos != prev_x || ypos != prev_y))
      vis_changes <= vis_changes + 1;
    prev_x  <= xpos;
    prev_y  <= ypos;
    prev_ok <= !rst;
  end

  // ---------------- helpers (called at a negedge) ----------------------------
  task automatic send_cmd(input int x, input int y, input int s);
    bit ok;
    ok = 0;
    cmd_x = 10'(x); cmd_y = 10'(y); cmd_step = 4'(s); cmd_valid = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if (cmd_ready) begin
        @(negedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    if (!ok) chk("send_cmd_timeout", 0, 1);
  endtask

  task automatic wait_tick();
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (frame_tick) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("wait_tick_timeout", 0, 1);
  endtask

  // Runs a command to completion; returns frame ticks seen until done.
  task automatic run_move(input int x, input int y, input int s, output int ticks);
    bit ok;
    ok = 0;
    ticks = 0;
    send_cmd(x, y, s);
    for (int i = 0; i < 4000; i++) begin
      if (done) begin
        ok = 1;
        break;
      end
      if (frame_tick) ticks++;
      @(negedge clk);
    end
    if (!ok) chk("run_move_timeout", 0, 1);
  endtask

  typedef struct {
    int x, y, s;
    int ex, ey, eticks;
  } move_t;

  move_t moves[8];

  initial begin
    int ticks, f0;
`ifdef PODIUM_SEQ_CLAMP_EN
    moves[5] = '{x:900,  y:10,   s:0,  ex:753,  ey:45,   eticks:1};
    moves[6] = '{x:0,    y:0,    s:15, ex:174,  ey:45,   eticks:39};
    moves[7] = '{x:1023, y:1023, s:15, ex:753,  ey:474,  eticks:39};
`else
    moves[5] = '{x:900,  y:10,   s:0,  ex:900,  ey:10,   eticks:1};
    moves[6] = '{x:0,    y:0,    s:15, ex:0,    ey:0,    eticks:60};
    moves[7] = '{x:1023, y:1023, s:15, ex:1023, ey:1023, eticks:69};
`endif
    moves[0] = '{x:250, y:215, s:0,  ex:250, ey:215, eticks:1};
    moves[1] = '{x:250, y:215, s:3,  ex:250, ey:215, eticks:1};
    moves[2] = '{x:260, y:200, s:5,  ex:260, ey:200, eticks:3};
    moves[3] = '{x:255, y:200, s:15, ex:255, ey:200, eticks:1};
    moves[4] = '{x:255, y:230, s:7,  ex:255, ey:230, eticks:5};

    rst = 1'b1; cmd_valid = 0; abort = 0; cmd_x = 0; cmd_y = 0; cmd_step = 0;
    repeat (3) @(negedge clk);
    chk("reset_xpos", xpos, 250);
    chk("reset_ypos", ypos, 215);
    chk("reset_ready", cmd_ready, 1);
    chk("reset_busy", busy, 0);
    rst = 1'b0;
    mon_en = 1;
    @(negedge clk);

    // Stepping move 250 -> 270 by 4.
    send_cmd(270, 215, 4);
    for (int k = 0; k < 5; k++) begin
      wait_tick();
      @(negedge clk);
      chk("step_xpos", xpos, 254 + 4 * k);
      chk("step_done", done, (k == 4) ? 1 : 0);
    end
    chk("step_busy_after", busy, 0);

    // Jump, then a short move that must not overshoot.
    send_cmd(100, 300, 0);
    wait_tick(); @(negedge clk);
    chk("jump_x", xpos, 100); chk("jump_y", ypos, 300); chk("jump_done", done, 1);
    send_cmd(103, 300, 8);
    wait_tick(); @(negedge clk);
    chk("noover_x", xpos, 103); chk("noover_done", done, 1);

    // Abort coinciding with the third tick.
    run_move(250, 215, 0, ticks);
    send_cmd(300, 215, 2);
    wait_tick(); @(negedge clk); chk("abort_pre1", xpos, 252);
    wait_tick(); @(negedge clk); chk("abort_pre2", xpos, 254);
    wait_tick();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_x", xpos, 254); chk("abort_busy", busy, 0);
    chk("abort_done", done, 0); chk("abort_ready", cmd_ready, 1);
    cmd_x = 10'd260; cmd_y = 10'd215; cmd_step = 4'd5; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("abort_reaccept_busy", busy, 1);
    for (int i = 0; i < 200 && !done; i++) @(negedge clk);
    chk("reaccept_done_x", xpos, 260);

    // Frame tick cadence with hCount held at 0 for 4 clocks.
    f0 = frame_cnt;
    for (int i = 0; i < 100 && frame_cnt == f0; i++) @(negedge clk);
    f0 = frame_cnt; ticks = 0;
    for (int i = 0; i < 1000 && frame_cnt < f0 + 5; i++) begin
      if (frame_tick) ticks++;
      @(negedge clk);
    end
    chk("ticks_per_5_frames", ticks, 5);

    // Table of moves: end point and number of frames to arrive.
    for (int i = 0; i < 8; i++) begin
      run_move(moves[i].x, moves[i].y, moves[i].s, ticks);
      chk($sformatf("move%0d_x", i), xpos, moves[i].ex);
      chk($sformatf("move%0d_y", i), ypos, moves[i].ey);
      chk($sformatf("move%0d_ticks", i), ticks, moves[i].eticks);
    end

    // Asynchronous reset in the middle of a move.
    send_cmd(300, 300, 1);
    wait_tick(); @(negedge clk);
    wait_tick(); @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_x", xpos, 250); chk("midrst_y", ypos, 215);
    chk("midrst_ready", cmd_ready, 1); chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Randomized traffic against the model.
    rand_hold = 1;
    for (int i = 0; i < 4000; i++) begin
      cmd_valid = ($urandom_range(0, 9) < 3);
      cmd_x     = 10'($urandom_range(0, 1023));
      cmd_y     = 10'($urandom_range(0, 1023));
      cmd_step  = 4'($urandom_range(0, 15));
      abort     = ($urandom_range(0, 39) == 0);
      @(negedge clk);
    end
    cmd_valid = 0; abort = 0;
    @(negedge clk);
    chk("visible_region_changes", vis_changes, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/podium_motion_sequencer.md
Name: podium_motion_sequencer

Overview:
- Owns and sequences the podium overlay's anchor position (xpos, ypos), which the podium renderer consumes.
- Accepts move commands through a valid/ready handshake.
- Steps the podium toward the commanded target by a fixed number of pixels per frame.
- Updates position only at a frame tick in vertical blanking, so the renderer never draws a torn podium.

Parameters:
- RESET_X, 250, xpos value after reset.
- RESET_Y, 215, ypos value after reset.
- FRAME_TICK_LINE, 516, vCount line (inside vertical blanking) on which the frame tick fires.
- X_MIN, 174, lowest legal xpos (used only with clamp feature).
- X_MAX, 753, highest legal xpos (used only with clamp feature).
- Y_MIN, 45, lowest legal ypos (used only with clamp feature).
- Y_MAX, 474, highest legal ypos (used only with clamp feature).

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  asynchronous, active-high reset.
- hCount  input  10  horizontal scan counter from the display timing block.
- vCount  input  10  vertical scan counter from the display timing block.
- cmd_valid  input  1  move command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_x  input  10  target xpos.
- cmd_y  input  10  target ypos.
- cmd_step  input  4  pixels per frame per axis; 0 means jump.
- abort  input  1  cancel the current move.
- xpos  output  10  current podium x anchor.
- ypos  output  10  current podium y anchor.
- busy  output  1  a move is pending or in progress.
- done  output  1  one-cycle pulse when a move completes.
- frame_tick  output  1  one-cycle frame-boundary pulse.

Behaviour:
- Reset is asynchronous: xpos=RESET_X, ypos=RESET_Y, state=IDLE, cmd_ready=1, busy=0, done=0, frame_tick=0, internal target/step registers cleared.
- Frame tick:
  - Condition is hCount==0 && vCount==FRAME_TICK_LINE.
  - hCount can hold for several clk cycles, so the condition is registered and edge-detected.
  - frame_tick is high for exactly one clk cycle, the cycle after the condition first becomes true. One pulse per frame.
- States:
  - IDLE: cmd_ready=1, busy=0. On cmd_valid, latch the target and step, then go to ARMED next cycle.
  - ARMED: cmd_ready=0, busy=1. Wait for frame_tick, then perform the first update (see MOVING) and go to MOVING, or go straight to IDLE if the target is reached.
  - MOVING: cmd_ready=0, busy=1. On each frame_tick, each axis moves toward its target by min(step, |target-current|).
    - Arithmetic is 11-bit signed difference.
    - Results never overshoot and never wrap.
    - When both axes equal the target after an update: go to IDLE and pulse done in the same cycle the position registers update.
- Step 0 (jump): at the first frame_tick, xpos/ypos load the target directly, done pulses, state returns to IDLE.
- Target equal to current position: the command is still accepted; done pulses at the first frame_tick.
- Position latency: xpos/ypos change only in the cycle frame_tick is high. They are stable for all other cycles, including the whole visible region.
- abort in ARMED or MOVING: return to IDLE next cycle, position frozen at its current value, no done pulse.
- abort coinciding with frame_tick: abort wins and no position update occurs.
- abort in IDLE: ignored. cmd_valid together with abort in IDLE: the command is accepted.
- cmd_valid while cmd_ready=0: not accepted. The requester must hold it; no command queueing.
- Mid-move rst: immediate return to reset values; the in-flight command is discarded.

Optional Feature:
- Macro PODIUM_SEQ_CLAMP_EN.
- When defined: cmd_x is clamped to [X_MIN, X_MAX] and cmd_y to [Y_MIN, Y_MAX] at acceptance, so the whole podium (10-px top, 40-px legs, 60-px width) stays in the visible area. The latched target is the clamped value.
- When undefined: targets are latched raw, and clamp parameters are unused.

Test Plan:
- Reset check: rst pulse mid-frame -> xpos=250, ypos=215, cmd_ready=1, busy=0, done=0 immediately, with no clk edge needed.
- Stepping move: cmd (x=270, y=215, step=4) -> xpos 254, 258, 262, 266, 270 on five successive frame_ticks. done pulses with the 270 update; busy falls next cycle.
- Jump and no-overshoot:
  - cmd (x=100, y=300, step=0) -> both load at the first frame_tick, done=1.
  - Then cmd (x=103, y=300, step=8) -> xpos=103 after one tick, with no overshoot.
- Abort: during a move step=2 from 250 toward 300, assert abort on the cycle of the 3rd frame_tick -> xpos stays 254, state IDLE, no done. A new cmd is accepted the next cycle.
- Frame tick timing: hCount held at 0 for 4 clk cycles with vCount=516 -> exactly one frame_tick per frame, and no xpos/ypos change while vCount is in 35..514.
- Clamp (PODIUM_SEQ_CLAMP_EN defined): cmd (x=900, y=10, step=0) -> xpos=753, ypos=45 at the first frame_tick. With the macro undefined: xpos=900, ypos=10.
